// File: rtl/acorn128_pkg.sv
// Shared constants for the ACORN-128 byte-serial frame loader: FSM encoding
// and frame/field geometry.
package acorn128_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEY   = 3'd1;
  localparam logic [2:0] ST_IV    = 3'd2;
  localparam logic [2:0] ST_AD    = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_START = 3'd5;
  localparam logic [2:0] ST_WAIT  = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  localparam int CMD_ENC_BIT = 7;
  localparam int CMD_LEN_MSB = 4;
  localparam int FIELD_BYTES = 16;
  localparam int BLOCK_W     = 128;

endpackage

// File: rtl/acorn128_byte_shreg.sv
// 128-bit byte-wide shift register: first byte in ends up most significant.
module acorn128_byte_shreg
  import acorn128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [7:0]         din,
  output logic [BLOCK_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[BLOCK_W-9:0], din};
    end
  end

endmodule

// File: rtl/acorn128_frame_loader.sv
// Byte-serial command frame loader feeding acorn128_top; optional core-wait
// watchdog enabled by defining ACORN_LOADER_TIMEOUT_EN.
module acorn128_frame_loader
  import acorn128_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data_in,
  input  logic               s_valid_in,
  output logic               s_ready_out,
  input  logic               core_ready_in,
  output logic               start_out,
  output logic               encrypt_out,
  output logic [BLOCK_W-1:0] key_out,
  output logic [BLOCK_W-1:0] iv_out,
  output logic [BLOCK_W-1:0] associated_data_out,
  output logic [BLOCK_W-1:0] plaintext_out,
  output logic [BLOCK_W-1:0] ciphertext_out,
  output logic [63:0]        data_length_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               len_err_out
`ifdef ACORN_LOADER_TIMEOUT_EN
  ,
  output logic               timeout_err_out
`endif
);

  if ((TIMEOUT_CYCLES >> TIMEOUT_W) != 0) begin : g_bad_timeout_cfg
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [2:0]         state;
  logic [3:0]         byte_cnt;
  logic [4:0]         len_q;
  logic               wait_armed;
  logic               byte_fire;
  logic               cmd_fire;
  logic [4:0]         cmd_len;
  logic [4:0]         cmd_len_clamped;
  logic               field_last;
  logic               data_last;
  logic [BLOCK_W-1:0] data_q;
`ifdef ACORN_LOADER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
`endif

  assign s_ready_out = (state == ST_IDLE) || (state == ST_KEY) || (state == ST_IV) ||
                       (state == ST_AD)   || (state == ST_DATA);
  assign byte_fire   = s_valid_in & s_ready_out;
  assign cmd_fire    = byte_fire & (state == ST_IDLE);

  assign cmd_len         = s_data_in[CMD_LEN_MSB:0];
  assign cmd_len_clamped = (cmd_len > 5'(FIELD_BYTES)) ? 5'(FIELD_BYTES) : cmd_len;

  assign field_last = (byte_cnt == 4'(FIELD_BYTES - 1));
  assign data_last  = (({1'b0, byte_cnt} + 5'd1) == len_q);

  // Field registers are wiped on every command so short data is right-justified.
  acorn128_byte_shreg u_key (
    .clk(clk), .rst(rst), .clr(cmd_fire),
    .shift_en(byte_fire & (state == ST_KEY)), .din(s_data_in), .q(key_out)
  );
  acorn128_byte_shreg u_iv (
    .clk(clk), .rst(rst), .clr(cmd_fire),
    .shift_en(byte_fire & (state == ST_IV)), .din(s_data_in), .q(iv_out)
  );
  acorn128_byte_shreg u_ad (
    .clk(clk), .rst(rst), .clr(cmd_fire),
    .shift_en(byte_fire & (state == ST_AD)), .din(s_data_in), .q(associated_data_out)
  );
  acorn128_byte_shreg u_data (
    .clk(clk), .rst(rst), .clr(cmd_fire),
    .shift_en(byte_fire & (state == ST_DATA)), .din(s_data_in), .q(data_q)
  );

  assign plaintext_out  = data_q;
  assign ciphertext_out = data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      byte_cnt        <= '0;
      len_q           <= '0;
      wait_armed      <= 1'b0;
      start_out       <= 1'b0;
      encrypt_out     <= 1'b0;
      data_length_out <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      len_err_out     <= 1'b0;
`ifdef ACORN_LOADER_TIMEOUT_EN
      wd_cnt          <= '0;
      timeout_err_out <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
`ifdef ACORN_LOADER_TIMEOUT_EN
      timeout_err_out <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            encrypt_out     <= s_data_in[CMD_ENC_BIT];
            len_q           <= cmd_len_clamped;
            len_err_out     <= (cmd_len > 5'(FIELD_BYTES));
            data_length_out <= {56'b0, cmd_len_clamped, 3'b000};
            busy_out        <= 1'b1;
            byte_cnt        <= '0;
            state           <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (byte_fire) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (field_last) state <= ST_IV;
          end
        end
        ST_IV: begin
          if (byte_fire) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (field_last) state <= ST_AD;
          end
        end
        ST_AD: begin
          if (byte_fire) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (field_last) begin
              if (len_q == 5'd0) begin
                state     <= ST_START;
                start_out <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (byte_fire) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (data_last) begin
              state     <= ST_START;
              start_out <= 1'b1;
            end
          end
        end
        ST_START: begin
          state      <= ST_WAIT;
          wait_armed <= 1'b0;
`ifdef ACORN_LOADER_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end
        ST_WAIT: begin
          // First WAIT cycle ignores core_ready_in: it may still be high from the last job.
          wait_armed <= 1'b1;
`ifdef ACORN_LOADER_TIMEOUT_EN
          wd_cnt     <= wd_cnt + 1'b1;
`endif
          if (wait_armed && core_ready_in) begin
            state     <= ST_DONE;
            start_out <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
          end
`ifdef ACORN_LOADER_TIMEOUT_EN
          else if (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state           <= ST_IDLE;
            start_out       <= 1'b0;
            busy_out        <= 1'b0;
            timeout_err_out <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acorn128_frame_loader.sv
// Scoreboard bench for acorn128_frame_loader: frames push expected words, a
// monitor checks them when start_out rises.
`timescale 1ns/1ps
module tb_acorn128_frame_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data_in;
  logic         s_valid_in;
  logic         s_ready_out;
  logic         core_ready_in;
  logic         start_out;
  logic         encrypt_out;
  logic [127:0] key_out;
  logic [127:0] iv_out;
  logic [127:0] associated_data_out;
  logic [127:0] plaintext_out;
  logic [127:0] ciphertext_out;
  logic [63:0]  data_length_out;
  logic         busy_out;
  logic         done_out;
  logic         len_err_out;
`ifdef ACORN_LOADER_TIMEOUT_EN
  logic         timeout_err_out;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] ad;
    logic [127:0] dat;
    logic [63:0]  len_bits;
    logic         enc;
    logic         lerr;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [127:0] K_FULL  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] IV_FULL = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] AD_FULL = 128'h11223344556677889900AABBCCDDEEFF;
  localparam logic [127:0] D_FULL  = 128'hAABBCCDDEEFF00112233445566778899;
  localparam logic [127:0] D_HELLO = 128'h0000000000_48656C6C6F2041434F524E;

  acorn128_frame_loader dut (
    .clk(clk),
    .rst(rst),
    .s_data_in(s_data_in),
    .s_valid_in(s_valid_in),
    .s_ready_out(s_ready_out),
    .core_ready_in(core_ready_in),
    .start_out(start_out),
    .encrypt_out(encrypt_out),
    .key_out(key_out),
    .iv_out(iv_out),
    .associated_data_out(associated_data_out),
    .plaintext_out(plaintext_out),
    .ciphertext_out(ciphertext_out),
    .data_length_out(data_length_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .len_err_out(len_err_out)
`ifdef ACORN_LOADER_TIMEOUT_EN
    ,
    .timeout_err_out(timeout_err_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge clk);
    s_data_in  = b;
    s_valid_in = 1'b1;
    while (!s_ready_out && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready_out) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_byte: s_ready_out stuck 0 for byte %h", b);
    end
    @(posedge clk);
  endtask

  // mode 0: ready after a few WAIT cycles, 1: stale ready held high, 2: never ready
  task automatic run_frame(input logic [7:0] cmd, input logic [127:0] k, input logic [127:0] v,
                           input logic [127:0] a, input logic [127:0] d, input int mode);
    exp_t e;
    int   lc;
    int   done_cnt;
    int   done_at;
    int   hs_bad;
    int   exp_done;
    int   limit;
`ifdef ACORN_LOADER_TIMEOUT_EN
    int   to_at;
    to_at = 0;
`endif
    lc         = (cmd[4:0] > 5'd16) ? 16 : int'(cmd[4:0]);
    e.key      = k;
    e.iv       = v;
    e.ad       = a;
    e.dat      = d;
    e.len_bits = 64'(lc * 8);
    e.enc      = cmd[7];
    e.lerr     = (cmd[4:0] > 5'd16);
    sb_q.push_back(e);

    core_ready_in = (mode == 1);
    send_byte(cmd);
    for (int i = 15; i >= 0; i--) send_byte(k[8*i +: 8]);
    for (int i = 15; i >= 0; i--) send_byte(v[8*i +: 8]);
    for (int i = 15; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = lc - 1; i >= 0; i--) send_byte(d[8*i +: 8]);
    #1;
    check("start_rise", start_out, 1);

    exp_done = (mode == 0) ? 7 : (mode == 1) ? 4 : 4098;
    limit    = (mode == 2) ? 4200 : 20;
    done_cnt = 0;
    done_at  = 0;
    hs_bad   = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) s_valid_in = 1'b0;
      if (mode == 0 && n == 6) core_ready_in = 1'b1;
      if (done_out) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        core_ready_in = 1'b0;
      end
      if (n < exp_done && (s_ready_out || !busy_out || !start_out)) hs_bad++;
`ifdef ACORN_LOADER_TIMEOUT_EN
      if (timeout_err_out && to_at == 0) to_at = n;
`endif
    end
    core_ready_in = 1'b0;
    check("start_wait_handshake", 128'(hs_bad), 0);
    if (mode == 2) begin
      check("timeout_no_done", 128'(done_cnt), 0);
`ifdef ACORN_LOADER_TIMEOUT_EN
      check("timeout_cycle", 128'(to_at), 4098);
`endif
    end else begin
      check("done_pulses", 128'(done_cnt), 1);
      check("done_cycle", 128'(done_at), 128'(exp_done));
    end
  endtask

  // Monitor: pops an expectation on every rising start_out.
  initial begin
    exp_t e;
    logic start_q;
    start_q = 1'b0;
    forever begin
      @(negedge clk);
      if (start_out && !start_q) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected_start: start_out rose with no frame pending");
        end else begin
          e = sb_q.pop_front();
          check("key", key_out, e.key);
          check("iv", iv_out, e.iv);
          check("ad", associated_data_out, e.ad);
          check("plaintext", plaintext_out, e.dat);
          check("ciphertext", ciphertext_out, e.dat);
          check("data_length", 128'(data_length_out), 128'(e.len_bits));
          check("encrypt", 128'(encrypt_out), 128'(e.enc));
          check("len_err", 128'(len_err_out), 128'(e.lerr));
        end
      end
      start_q = start_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst           = 1'b0;
    s_data_in     = 8'h00;
    s_valid_in    = 1'b0;
    core_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", s_ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_start", start_out, 0);
    check("rst_len_err", len_err_out, 0);
    check("rst_key", key_out, 0);
    check("rst_len", 128'(data_length_out), 0);
    @(negedge clk);
    rst = 1'b1;

    run_frame(8'h90, K_FULL, IV_FULL, AD_FULL, D_FULL, 0);
    check("hold_key", key_out, K_FULL);
    check("hold_data", plaintext_out, D_FULL);
    check("hold_len", 128'(data_length_out), 128);

    run_frame(8'h8B, K_FULL, IV_FULL, AD_FULL, D_HELLO, 0);
    run_frame(8'h80, K_FULL, IV_FULL, AD_FULL, 128'h0, 0);
    run_frame(8'h9F, K_FULL, IV_FULL, AD_FULL, D_FULL, 0);
    run_frame(8'h10, IV_FULL, K_FULL, D_FULL, AD_FULL, 1);

    // Reset in the middle of IV: 16 key bytes and 7 IV bytes already taken.
    send_byte(8'h90);
    for (int i = 15; i >= 0; i--) send_byte(K_FULL[8*i +: 8]);
    for (int i = 15; i >= 9; i--) send_byte(IV_FULL[8*i +: 8]);
    @(negedge clk);
    s_valid_in = 1'b0;
    rst        = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_key", key_out, 0);
    check("midrst_iv", iv_out, 0);
    check("midrst_busy", busy_out, 0);
    check("midrst_enc", encrypt_out, 0);
    check("midrst_len", 128'(data_length_out), 0);
    check("midrst_idle", s_ready_out, 1);
    @(negedge clk);
    rst = 1'b1;

`ifdef ACORN_LOADER_TIMEOUT_EN
    run_frame(8'h90, K_FULL, IV_FULL, AD_FULL, D_FULL, 2);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acorn128_frame_loader.md
Name: acorn128_frame_loader

Overview:
- Upstream feeder for acorn128_top.
- Accepts a byte-serial command frame over a valid/ready handshake and assembles 128-bit key, IV, associated data and data words.
- Launches one core operation, holds all core inputs stable, and waits for the core's ready_out.
- Lets the core be driven from a narrow byte link (UART/SPI bridge) instead of wide parallel registers.

Parameters:
- TIMEOUT_CYCLES, 4096: core-wait watchdog limit in clk cycles; used only with the optional feature.
- TIMEOUT_W, 13: width of the watchdog counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- s_data_in  in  8  frame byte.
- s_valid_in  in  1  s_data_in valid.
- s_ready_out  out  1  loader accepts a byte this cycle.
- core_ready_in  in  1  ready_out from acorn128_top.
- start_out  out  1  to core start_in.
- encrypt_out  out  1  to core encrypt_in.
- key_out  out  128  to core key_in.
- iv_out  out  128  to core iv_in.
- associated_data_out  out  128  to core associated_data_in.
- plaintext_out  out  128  to core plaintext_in; carries the data word.
- ciphertext_out  out  128  to core ciphertext_in; same value as plaintext_out.
- data_length_out  out  64  data length in bits (len*8).
- busy_out  out  1  high from command accept until DONE.
- done_out  out  1  one-cycle pulse when the core reports ready.
- len_err_out  out  1  sticky; command length field exceeded 16.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; every output and internal register goes to 0. This applies from any state, including mid-frame and during WAIT.
- Byte transfer: occurs on a cycle with s_valid_in & s_ready_out.
  - s_ready_out=1 only in IDLE, KEY, IV, AD and DATA; 0 in START, WAIT and DONE.
- Command byte (accepted in IDLE):
  - bit7 = encrypt.
  - bits4:0 = len, in bytes.
  - bits6:5 are ignored.
- On command accept:
  - Latch encrypt_out and clear the key, IV, AD and data registers to 0.
  - If len>16: clamp len to 16 and set len_err_out=1. len_err_out clears on the next command accept whose len<=16.
  - data_length_out = {56'b0, len_clamped, 3'b0}.
  - busy_out=1.
- Field shifting: each field register shifts left 8 and inserts the byte at [7:0]. The first byte received ends up most significant (Verilog string order).
  - KEY, IV and AD each take exactly 16 bytes.
  - DATA takes len bytes. With fewer than 16, the value is right-justified with zero upper bytes. Example: "Hello ACORN" = 11 bytes gives 0x00..48656C6C6F2041434F524E.
- Byte counter: 4-bit, wraps at 15.
- State transitions:
  - IDLE to KEY on command byte.
  - KEY to IV, and IV to AD, on the 16th byte.
  - AD to DATA on the 16th byte, or AD to START if len==0.
  - DATA to START on byte number len.
  - START: start_out rises, and one cycle later the state goes to WAIT.
  - WAIT: start_out stays high. The state goes to DONE on the first cycle core_ready_in=1, counting only from the second WAIT cycle onward. This masks a stale ready from the previous operation.
  - DONE: start_out=0, busy_out=0, done_out=1 for one cycle, then IDLE.
- Output hold: key, IV, AD, data, encrypt and data_length outputs hold their values through DONE and in IDLE until the next command accept.
- No abort path exists other than rst (and the optional timeout).

Optional Feature:
- ACORN_LOADER_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT.
  - On reaching TIMEOUT_CYCLES: start_out=0, timeout_err_out (extra 1-bit output) pulses for one cycle, done_out is not asserted, and the state returns to IDLE.
  - The counter clears on entering WAIT.
- Macro undefined: no counter and no timeout_err_out port; WAIT waits indefinitely.

Decomposition:
- acorn128_pkg:
  - state encoding (IDLE, KEY, IV, AD, DATA, START, WAIT, DONE);
  - CMD_ENC_BIT=7;
  - CMD_LEN_MSB=4;
  - FIELD_BYTES=16;
  - BLOCK_W=128.
- Sub-module acorn128_byte_shreg: 128-bit register with synchronous clear, byte shift-in enable, and active-low synchronous reset. It is instantiated four times (key, IV, AD, data).

Test Plan:
- Full frame: command 0x90, key 00112233..EEFF, IV 0123456789ABCDEF x2, AD 11223344..EEFF, data AABBCCDD..8899. Required: start_out rises 1 cycle after the last byte; all outputs equal the sent words; data_length_out=128.
- Short data: command 0x8B with "Hello ACORN". Required: plaintext_out=0x0000_0000_0048656C6C6F2041434F524E and data_length_out=88.
- len=0: command 0x80. Required: AD goes straight to START; plaintext_out=0; data_length_out=0.
- len=31 (command 0x9F): len_err_out=1 and data_length_out=128. A following command 0x10 clears len_err_out and gives encrypt_out=0.
- Stale ready: hold core_ready_in=1 through START. Required: done_out is not asserted before the second WAIT cycle, then pulses exactly once; s_ready_out=0 throughout START/WAIT.
- Reset mid-IV after 7 bytes: all outputs 0 and state IDLE next cycle. With the macro defined, core_ready_in stuck at 0 gives timeout_err_out after 4096 WAIT cycles.
